data_ram: RTL and testbench



---
 rtl/data_ram_pkg.sv | 26 ++
 rtl/data_ram_lane_gen.sv | 34 +++
 rtl/data_ram.sv | 102 ++++++++++
 tb/tb_data_ram.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/data_ram_pkg.sv
// Shared memory-op encodings and bus types for the data RAM and the execute stage.
package data_ram_pkg;

  localparam int RAM_ADDR_W     = 32;
  localparam int RAM_DATA_W     = 32;
  localparam int DATA_RAM_DEPTH = 4096;
  localparam int LANE_MASK_W    = RAM_DATA_W / 8;

  typedef logic [RAM_ADDR_W-1:0]  ram_addr_t;
  typedef logic [RAM_DATA_W-1:0]  ram_data_t;
  typedef logic [LANE_MASK_W-1:0] lane_mask_t;

  // Codes outside this set are treated as full-word accesses.
  typedef enum logic [2:0] {
    CTRL_MEM_OP_BYTE  = 3'b000,
    CTRL_MEM_OP_HALF  = 3'b001,
    CTRL_MEM_OP_WORD  = 3'b010,
    CTRL_MEM_OP_UBYTE = 3'b100,
    CTRL_MEM_OP_UHALF = 3'b101
  } ctrl_mem_op_e;

  function automatic ram_data_t lane_shift(input ram_data_t word, input logic [1:0] ofs);
    return word >> {ofs, 3'b000};
  endfunction

endpackage

// File: rtl/data_ram_lane_gen.sv
// Byte-lane generator: byte-enable mask, lane-replicated write data and
// alignment flag for one access.
module data_ram_lane_gen
  import data_ram_pkg::*;
(
  input  logic [2:0]             op_i,
  input  logic [1:0]             addr_lo_i,
  input  logic [RAM_DATA_W-1:0]  data_i,
  output logic [LANE_MASK_W-1:0] mask_o,
  output logic [RAM_DATA_W-1:0]  data_o,
  output logic                   misaligned_o
);

  always_comb begin
    mask_o       = '1;
    data_o       = data_i;
    misaligned_o = 1'b0;
    case (op_i)
      CTRL_MEM_OP_BYTE, CTRL_MEM_OP_UBYTE: begin
        mask_o = lane_mask_t'(4'b0001) << addr_lo_i;
        data_o = {4{data_i[7:0]}};
      end
      CTRL_MEM_OP_HALF, CTRL_MEM_OP_UHALF: begin
        mask_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        data_o       = {2{data_i[15:0]}};
        misaligned_o = addr_lo_i[0];
      end
      default: begin
        misaligned_o = (addr_lo_i != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/data_ram.sv
// Single-port-per-direction data memory: byte-lane stores, write-first loads
// returned right-aligned one cycle later, and a misalignment pulse for traps.
module data_ram
  import data_ram_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DATA_RAM_DEPTH,
  parameter int unsigned IDX_W       = 12
) (
  input  logic                  i_Clk,
  input  logic                  i_reset,
  input  logic                  i_we,
  input  logic [RAM_ADDR_W-1:0] i_w_addr,
  input  logic [RAM_DATA_W-1:0] i_w_data,
  input  logic [2:0]            i_w_op,
  input  logic                  i_re,
  input  logic [RAM_ADDR_W-1:0] i_r_addr,
  input  logic [2:0]            i_r_op,
  output logic [RAM_DATA_W-1:0] o_r_data,
  output logic                  o_r_valid,
  output logic                  o_misaligned
);

  logic [RAM_DATA_W-1:0] mem_q [DEPTH_WORDS];

  logic [RAM_DATA_W-1:0]  r_data_q, r_data_d;
  logic                   r_valid_q;
  logic                   misaligned_q, misaligned_d;

  logic [LANE_MASK_W-1:0] st_mask;
  logic [RAM_DATA_W-1:0]  st_lanes;
  logic                   st_mis;
  logic                   ld_mis;
  logic                   st_en;
  logic [IDX_W-1:0]       w_idx, r_idx;
  logic [RAM_DATA_W-1:0]  rd_word;

  logic [LANE_MASK_W-1:0] unused_ld_mask;
  logic [RAM_DATA_W-1:0]  unused_ld_data;
  logic                   unused_addr_hi;

  data_ram_lane_gen u_store_lanes (
    .op_i         (i_w_op),
    .addr_lo_i    (i_w_addr[1:0]),
    .data_i       (i_w_data),
    .mask_o       (st_mask),
    .data_o       (st_lanes),
    .misaligned_o (st_mis)
  );

  data_ram_lane_gen u_load_lanes (
    .op_i         (i_r_op),
    .addr_lo_i    (i_r_addr[1:0]),
    .data_i       ('0),
    .mask_o       (unused_ld_mask),
    .data_o       (unused_ld_data),
    .misaligned_o (ld_mis)
  );

  // Address bits above the word index are ignored, so addresses alias.
  assign unused_addr_hi = ^{i_w_addr[RAM_ADDR_W-1:IDX_W+2], i_r_addr[RAM_ADDR_W-1:IDX_W+2]};

  assign w_idx = i_w_addr[IDX_W+1:2];
  assign r_idx = i_r_addr[IDX_W+1:2];
  assign st_en = i_we && !st_mis && !i_reset;

  // Write-first: a same-word load sees the post-store lanes.
  always_comb begin
    rd_word = mem_q[r_idx];
    if (st_en && (w_idx == r_idx)) begin
      for (int b = 0; b < LANE_MASK_W; b++) begin
        if (st_mask[b]) rd_word[8*b +: 8] = st_lanes[8*b +: 8];
      end
    end
    r_data_d     = lane_shift(rd_word, i_r_addr[1:0]);
    misaligned_d = (i_we && st_mis) || (i_re && ld_mis);
  end

  always_ff @(posedge i_Clk) begin
    if (st_en) begin
      for (int b = 0; b < LANE_MASK_W; b++) begin
        if (st_mask[b]) mem_q[w_idx][8*b +: 8] <= st_lanes[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_reset) begin
      r_data_q     <= '0;
      r_valid_q    <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      r_valid_q    <= i_re;
      misaligned_q <= misaligned_d;
      if (i_re) r_data_q <= r_data_d;
    end
  end

  assign o_r_data     = r_data_q;
  assign o_r_valid    = r_valid_q;
  assign o_misaligned = misaligned_q;

endmodule

// File: tb/tb_data_ram.sv
// Scoreboard bench for data_ram: a reference word array predicts every load,
// expected results are queued at issue and popped when o_r_valid returns them.
module tb_data_ram;
  import data_ram_pkg::*;

  localparam int IDX_W = 12;
  localparam int DEPTH = 4096;

  logic        clk;
  logic        rst;
  logic        we, re;
  logic [31:0] w_addr, w_data, r_addr;
  logic [2:0]  w_op, r_op;
  logic [31:0] r_data;
  logic        r_valid, misaligned;

  logic [31:0] m [DEPTH];
  logic [31:0] sb [$];
  logic [31:0] last_data;
  int          n_checks, n_errors;

  data_ram #(.DEPTH_WORDS(DEPTH), .IDX_W(IDX_W)) dut (
    .i_Clk        (clk),
    .i_reset      (rst),
    .i_we         (we),
    .i_w_addr     (w_addr),
    .i_w_data     (w_data),
    .i_w_op       (w_op),
    .i_re         (re),
    .i_r_addr     (r_addr),
    .i_r_op       (r_op),
    .o_r_data     (r_data),
    .o_r_valid    (r_valid),
    .o_misaligned (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic bit is_mis(input logic [2:0] op, input logic [31:0] a);
    if (op == 3'b000 || op == 3'b100) return 1'b0;
    if (op == 3'b001 || op == 3'b101) return a[0];
    return a[1:0] != 2'b00;
  endfunction

  task automatic model_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    int idx;
    idx = int'(a[IDX_W+1:2]);
    if (op == 3'b000 || op == 3'b100)      m[idx][8*a[1:0] +: 8]  = d[7:0];
    else if (op == 3'b001 || op == 3'b101) m[idx][16*a[1] +: 16]  = d[15:0];
    else                                   m[idx]                 = d;
  endtask

  task automatic cyc(input string tag, input logic r, input logic w_en,
                     input logic [31:0] wa, input logic [31:0] wd, input logic [2:0] wo,
                     input logic r_en, input logic [31:0] ra, input logic [2:0] ro);
    logic exp_v, exp_m;
    logic [31:0] exp_d;
    @(negedge clk);
    rst = r; we = w_en; w_addr = wa; w_data = wd; w_op = wo;
    re = r_en; r_addr = ra; r_op = ro;
    exp_v = r_en && !r;
    exp_m = !r && ((w_en && is_mis(wo, wa)) || (r_en && is_mis(ro, ra)));
    if (!r && w_en && !is_mis(wo, wa)) model_store(wo, wa, wd);
    if (exp_v) sb.push_back(m[int'(ra[IDX_W+1:2])] >> (8 * ra[1:0]));
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, {31'b0, r_valid}, {31'b0, exp_v});
    chk({tag, ".misaligned"}, {31'b0, misaligned}, {31'b0, exp_m});
    if (r) last_data = '0;
    if (exp_v) begin
      exp_d = sb.pop_front();
      chk({tag, ".data"}, r_data, exp_d);
      last_data = exp_d;
    end else begin
      chk({tag, ".hold"}, r_data, last_data);
    end
  endtask

  task automatic st(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    cyc(tag, 1'b0, 1'b1, a, d, op, 1'b0, 32'h0, CTRL_MEM_OP_WORD);
  endtask

  task automatic ld(input string tag, input logic [2:0] op, input logic [31:0] a);
    cyc(tag, 1'b0, 1'b0, 32'h0, 32'h0, CTRL_MEM_OP_WORD, 1'b1, a, op);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 1'b0, 1'b0, 32'h0, 32'h0, CTRL_MEM_OP_WORD, 1'b0, 32'h0, CTRL_MEM_OP_WORD);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; last_data = '0;
    rst = 1'b1; we = 1'b0; re = 1'b0;
    w_addr = '0; w_data = '0; w_op = CTRL_MEM_OP_WORD;
    r_addr = '0; r_op = CTRL_MEM_OP_WORD;
    for (int i = 0; i < DEPTH; i++) m[i] = '0;

    cyc("reset0", 1'b1, 1'b0, 32'h0, 32'h0, CTRL_MEM_OP_WORD, 1'b0, 32'h0, CTRL_MEM_OP_WORD);
    cyc("reset1", 1'b1, 1'b0, 32'h0, 32'h0, CTRL_MEM_OP_WORD, 1'b1, 32'h0, CTRL_MEM_OP_WORD);
    chk("reset.data", r_data, 32'h0);

    for (int i = 0; i < 64; i++) st("init", CTRL_MEM_OP_WORD, 32'(i * 4), $urandom);

    st("word_st", CTRL_MEM_OP_WORD, 32'h100, 32'hDEADBEEF);
    ld("word_ld", CTRL_MEM_OP_WORD, 32'h100);
    chk("word_ld.const", r_data, 32'hDEADBEEF);
    idle("word_after");

    st("lane_base", CTRL_MEM_OP_WORD, 32'h200, 32'h11223344);
    st("lane_byte", CTRL_MEM_OP_BYTE, 32'h203, 32'h000000AA);
    ld("lane_word", CTRL_MEM_OP_WORD, 32'h200);
    chk("lane_word.const", r_data, 32'hAA223344);
    ld("lane_ubyte", CTRL_MEM_OP_UBYTE, 32'h203);
    chk("lane_ubyte.const", r_data, 32'h000000AA);

    st("half_base", CTRL_MEM_OP_WORD, 32'h300, 32'h0);
    st("half_st", CTRL_MEM_OP_HALF, 32'h302, 32'h1234BEEF);
    ld("half_ld", CTRL_MEM_OP_HALF, 32'h302);
    chk("half_ld.const", r_data, 32'h0000BEEF);
    st("half_mis", CTRL_MEM_OP_UHALF, 32'h301, 32'h00005555);
    chk("half_mis.pulse", {31'b0, misaligned}, 32'h1);
    idle("half_mis_clear");
    ld("half_unchanged", CTRL_MEM_OP_WORD, 32'h300);
    chk("half_unchanged.const", r_data, 32'hBEEF0000);

    st("rdw_base", CTRL_MEM_OP_WORD, 32'h400, 32'h0);
    cyc("rdw", 1'b0, 1'b1, 32'h400, 32'h12345678, CTRL_MEM_OP_WORD, 1'b1, 32'h400, CTRL_MEM_OP_WORD);
    chk("rdw.const", r_data, 32'h12345678);
    cyc("rdw_byte", 1'b0, 1'b1, 32'h401, 32'h000000EE, CTRL_MEM_OP_BYTE, 1'b1, 32'h400, CTRL_MEM_OP_WORD);
    chk("rdw_byte.const", r_data, 32'h1234EE78);
    cyc("split", 1'b0, 1'b1, 32'h404, 32'h0BADF00D, CTRL_MEM_OP_WORD, 1'b1, 32'h100, CTRL_MEM_OP_WORD);

    st("wrap_st", CTRL_MEM_OP_WORD, 32'h4000, 32'hCAFEF00D);
    ld("wrap_ld", CTRL_MEM_OP_WORD, 32'h0);
    chk("wrap_ld.const", r_data, 32'hCAFEF00D);

    ld("mis_ld", CTRL_MEM_OP_WORD, 32'h101);
    chk("mis_ld.const", r_data, 32'h00DEADBE);

    for (int i = 0; i < 300; i++) begin
      cyc("rand", 1'b0, 1'($urandom), $urandom & 32'hFFFFC0FF, $urandom, 3'($urandom_range(0, 7)),
          1'($urandom), $urandom & 32'hFFFFC0FF, 3'($urandom_range(0, 7)));
    end

    st("rst_pre", CTRL_MEM_OP_WORD, 32'h500, 32'h55555555);
    ld("rst_pend", CTRL_MEM_OP_WORD, 32'h500);
    cyc("rst_mid", 1'b1, 1'b1, 32'h500, 32'h99999999, CTRL_MEM_OP_WORD, 1'b1, 32'h100, CTRL_MEM_OP_WORD);
    chk("rst_mid.data", r_data, 32'h0);
    ld("rst_dropped", CTRL_MEM_OP_WORD, 32'h500);
    chk("rst_dropped.const", r_data, 32'h55555555);
    ld("rst_survive", CTRL_MEM_OP_WORD, 32'h100);
    chk("rst_survive.const", r_data, 32'hDEADBEEF);
    idle("end");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
